// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline definitions: datapath width, the canonical NOP
// encoding, and the fetch-stage state encoding.
package riscv_pkg;

    localparam int XLEN = 32;

    // addi x0, x0, 0
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    // Word size in bytes, used for sequential PC advance.
    localparam logic [XLEN-1:0] INSTR_BYTES = 32'd4;

    typedef enum logic [1:0] {
        REQ   = 2'd0,   // request on the bus, waiting for acceptance
        WAIT  = 2'd1,   // request accepted, waiting for the response
        HOLD  = 2'd2,   // response parked in the skid buffer, decode stalled
        DRAIN = 2'd3    // a stale response is owed and must be thrown away
    } fetch_state_t;

endpackage : riscv_pkg

// File: rtl/if_id_reg.sv
// Pipeline register carrying {valid, instr, pc, pc+4} between stages.
// Flush wins over load; a flushed or reset register presents a NOP so that
// downstream decode never sees stale instruction bits.
module if_id_reg
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] NOP_VALUE = riscv_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            flush,
    input  logic [XLEN-1:0] instr_in,
    input  logic [XLEN-1:0] pc_in,
    input  logic [XLEN-1:0] pc4_in,
    output logic            valid,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc4
);

    logic            valid_q, valid_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] pc_q,    pc_d;
    logic [XLEN-1:0] pc4_q,   pc4_d;

    // Next contents: flush inserts a bubble, load captures new data, else hold.
    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        pc4_d   = pc4_q;
        if (flush) begin
            valid_d = 1'b0;
            instr_d = NOP_VALUE;
        end else if (load) begin
            valid_d = 1'b1;
            instr_d = instr_in;
            pc_d    = pc_in;
            pc4_d   = pc4_in;
        end
    end

    // Register with synchronous reset to an empty NOP slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            instr_q <= NOP_VALUE;
            pc_q    <= '0;
            pc4_q   <= '0;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
            pc4_q   <= pc4_d;
        end
    end

    assign valid = valid_q;
    assign instr = instr_q;
    assign pc    = pc_q;
    assign pc4   = pc4_q;

endmodule : if_id_reg

// File: rtl/fetch_stage.sv
// RV32I instruction fetch: PC register, single-outstanding request FSM,
// one-entry skid buffer for responses that arrive while decode is stalled,
// and the IF/ID output register.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            stall,
    output logic            if_valid,
    output logic [XLEN-1:0] if_instr,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_pc4
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] skid_instr_q, skid_instr_d;
    logic [XLEN-1:0] skid_pc_q, skid_pc_d;

    logic            id_load;
    logic            id_flush;
    logic [XLEN-1:0] id_instr;
    logic [XLEN-1:0] id_pc;
    logic [XLEN-1:0] id_pc4;

    logic            can_load;
    logic            consumed;
    logic            rsp_owed;
    logic [XLEN-1:0] pc_plus4;

    assign can_load = !if_valid || !stall;
    assign consumed = if_valid && !stall;
    assign pc_plus4 = pc_q + INSTR_BYTES;

    // A response is still outstanding after this cycle if one was accepted
    // (or is being accepted now) and has not shown up yet. DRAIN counts too:
    // a redirect there must keep waiting for the stale word.
    assign rsp_owed = ((state_q == WAIT)  && !imem_rsp_valid) ||
                      ((state_q == REQ)   &&  imem_req_ready) ||
                      ((state_q == DRAIN) && !imem_rsp_valid);

    // Next-state, PC, skid buffer and IF/ID control; redirect overrides all.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        id_load      = 1'b0;
        id_instr     = imem_rsp_data;
        id_pc        = pc_q;
        id_pc4       = pc_plus4;

        if (redirect_valid) begin
            pc_d    = redirect_pc & ~32'h0000_0003;
            state_d = rsp_owed ? DRAIN : REQ;
        end else begin
            unique case (state_q)
                REQ: begin
                    if (imem_req_ready) begin
                        state_d = WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rsp_valid) begin
                        pc_d = pc_plus4;
                        if (can_load) begin
                            id_load = 1'b1;
                            state_d = REQ;
                        end else begin
                            skid_instr_d = imem_rsp_data;
                            skid_pc_d    = pc_q;
                            state_d      = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (can_load) begin
                        id_load  = 1'b1;
                        id_instr = skid_instr_q;
                        id_pc    = skid_pc_q;
                        id_pc4   = skid_pc_q + INSTR_BYTES;
                        state_d  = REQ;
                    end
                end
                DRAIN: begin
                    if (imem_rsp_valid) begin
                        state_d = REQ;
                    end
                end
                default: begin
                    state_d = REQ;
                end
            endcase
        end

        // Redirect flushes even under stall; otherwise a consumed slot with
        // nothing new behind it becomes a bubble.
        id_flush = redirect_valid || (consumed && !id_load);
    end

    // State, PC and skid buffer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= REQ;
            pc_q         <= RESET_PC;
            skid_instr_q <= NOP_INSTR;
            skid_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
        end
    end

    assign imem_req_valid = (state_q == REQ);
    assign imem_addr      = pc_q;

    if_id_reg #(
        .NOP_VALUE (NOP_INSTR)
    ) u_if_id (
        .clk      (clk),
        .rst      (rst),
        .load     (id_load),
        .flush    (id_flush),
        .instr_in (id_instr),
        .pc_in    (id_pc),
        .pc4_in   (id_pc4),
        .valid    (if_valid),
        .instr    (if_instr),
        .pc       (if_pc),
        .pc4      (if_pc4)
    );

endmodule : fetch_stage
